eight_bit_add_sub_core: RTL and testbench
=========================================

// Module: eight_bit_add_sub_core
// PURPOSE
//   Registered 8-bit signed two's-complement adder/subtractor with a signed-overflow flag.
//   It is a datapath primitive for small ALUs.
//   opcode selects add (0) or subtract (1).
//   The result and overflow flag are captured in output registers, giving one cycle of latency.
// PARAMETERS
//   none. Width is fixed at 8 bits.
// PORTS
//   clk     in   1  single clock; all state updates on the rising edge
//   rst     in   1  reset, asynchronous, active-high
//   a       in   8  signed operand A (two's complement)
//   b       in   8  signed operand B (two's complement)
//   opcode  in   1  0 = A+B, 1 = A-B
//   sum     out  8  signed result, registered
//   ovf     out  1  signed-overflow flag, registered
// BEHAVIOUR
//   - Reset: while rst=1, sum=8'h00 and ovf=0 immediately, independent of clk.
//     After rst deasserts, the first rising edge captures a new result.
//   - Datapath: ripple chain of 8 full adders.
//       - Bit i receives a[i] and b[i]^opcode.
//       - Carry-in c0 = opcode, so subtract is A + ~B + 1.
//   - Result: sum_next = (A + (opcode ? -B : B)) mod 256.
//     The result wraps; no width growth is exposed.
//   - Overflow: ovf_next = c7 ^ c8, where c7 is the carry into the MSB and c8 is the carry out.
//     Equivalently, the true signed result lies outside [-128, 127].
//   - Carry-out c8 is internal only; it is not a port.
//   - Latency: inputs sampled at edge N appear on sum/ovf after edge N.
//     Outputs hold until the next edge; there is no handshake and no enable.
//   - Boundaries:
//       - -128-1 -> 127, ovf=1.
//       - 0-(-128) -> -128, ovf=1.
//       - -128+(-128) -> 0, ovf=1.
//       - 127+1 -> -128, ovf=1.
//       - x-x -> 0, ovf=0.
//   - Inputs outside 8 bits are truncated at the port.
//     Example: b=-129 arrives as 127; b=-135 arrives as 121.
//   - Reset mid-stream discards the in-flight result; outputs return to 0.
// CONFIGURATION
//   - Macro ADD_SUB_SATURATE_EN:
//       - Defined: when ovf_next=1, sum_next is clamped.
//         Clamp to 127 if the true result is positive, i.e. A[7]=0.
//         Clamp to -128 if it is negative, i.e. A[7]=1.
//         ovf still reports the overflow.
//       - Undefined: sum wraps modulo 256 as described above.
//   - Non-overflow results are identical in both builds.
// TESTING
//   Each check is made one clock after the inputs are applied; reset is asserted first.
//   - Reset: assert rst mid-cycle with outputs nonzero -> sum=0, ovf=0 at once, before any clk edge.
//   - No-overflow cases:
//       - 11+33 -> 44, ovf=0.
//       - -12+90 -> 78, ovf=0.
//       - 120-45 -> 75, ovf=0.
//       - 99-5 -> 94, ovf=0.
//       - 0-4 -> -4, ovf=0.
//       - 10-89 -> -79, ovf=0.
//   - Overflow with wrap (no macro):
//       - 120+45 -> -91, ovf=1.
//       - 104+24 -> -128, ovf=1.
//       - 67+(-129, i.e. 127) -> -62, ovf=1.
//   - Negatives:
//       - -10+(-99) -> -109, ovf=0.
//       - 20+(-45) -> -25, ovf=0.
//       - 78-(-135, i.e. 121) -> -43, ovf=0.
//       - 112-35 -> 77, ovf=0.
//   - Edges:
//       - -128-1 -> 127, ovf=1.
//       - 0-(-128) -> -128, ovf=1.
//       - 127+1 -> -128, ovf=1.
//   - ADD_SUB_SATURATE_EN defined:
//       - 120+45 -> 127, ovf=1.
//       - -128-1 -> -128, ovf=1.
//       - 11+33 -> 44, ovf=0.

Source files
------------

// File: rtl/eight_bit_add_sub_core.sv
// Registered 8-bit signed adder/subtractor with signed-overflow flag, one cycle latency.
// Optional macro ADD_SUB_SATURATE_EN clamps overflowing results instead of wrapping.
module eight_bit_add_sub_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       opcode,
  output logic [7:0] sum,
  output logic       ovf
);

  logic [8:0] c;
  logic [7:0] bx;
  logic [7:0] s_raw;
  logic [7:0] sum_next;
  logic       ovf_next;

  // Ripple chain: subtract is a + ~b + 1, so opcode both inverts b and seeds the carry.
  always_comb begin
    c     = '0;
    s_raw = '0;
    bx    = b ^ {8{opcode}};
    c[0]  = opcode;
    for (int unsigned i = 0; i < 8; i++) begin
      s_raw[i] = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    ovf_next = c[7] ^ c[8];
    sum_next = s_raw;
`ifdef ADD_SUB_SATURATE_EN
    // On overflow the true result shares the sign of a.
    if (ovf_next) begin
      sum_next = a[7] ? 8'h80 : 8'h7f;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      ovf <= 1'b0;
    end else begin
      sum <= sum_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_eight_bit_add_sub_core.sv
// Scoreboard bench for eight_bit_add_sub_core: directed boundary vectors plus random ones,
// checked against an integer-arithmetic reference model.
module tb_eight_bit_add_sub_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       opcode = 1'b0;
  logic [7:0] sum;
  logic       ovf;

  int checks = 0;
  int failures = 0;

  logic [8:0] exp_q[$];

  eight_bit_add_sub_core dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .opcode(opcode), .sum(sum), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv, input logic op);
    int sa, sb, t, r;
    logic [31:0] rv;
    logic o;
    sa = $signed(av);
    sb = $signed(bv);
    t  = op ? sa - sb : sa + sb;
    o  = (t > 127) || (t < -128);
    r  = t;
`ifdef ADD_SUB_SATURATE_EN
    if (t > 127) r = 127;
    if (t < -128) r = -128;
`endif
    rv = 32'(r);
    return {o, rv[7:0]};
  endfunction

  task automatic drive(input int av, input int bv, input logic op);
    logic [31:0] x, y;
    @(negedge clk);
    x = 32'(av);
    y = 32'(bv);
    a = x[7:0];
    b = y[7:0];
    opcode = op;
    exp_q.push_back(model(x[7:0], y[7:0], op));
  endtask

  // Monitor: every edge with a pending expectation yields one registered result.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({ovf, sum} !== e) begin
        failures++;
        $display("FAIL result a=%0d b=%0d op=%0b: got sum=%0d ovf=%0b, want sum=%0d ovf=%0b",
                 $signed(a), $signed(b), opcode, $signed(sum), ovf, $signed(e[7:0]), e[8]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  int da[19] = '{11, -12, 120, 99, 0, 10, 120, 104, 67, -10, 20, 78, 112, -128, 0, 127, -128, 55, -77};
  int db[19] = '{33,  90,  45,  5, 4, 89,  45,  24, -129, -99, -45, -135, 35, 1, -128, 1, -128, 55, -77};
  logic dop[19] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sum !== 8'h00 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got sum=%0h ovf=%0b, want sum=00 ovf=0", sum, ovf);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) drive(da[i], db[i], dop[i]);
    for (int i = 0; i < 300; i++)
      drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // Mid-cycle reset with nonzero outputs: clears at once, without a clock edge.
    drive(11, 33, 1'b0);
    @(posedge clk);
    #3;
    checks++;
    if (sum !== 8'd44) begin
      failures++;
      $display("FAIL pre_reset_value: got sum=%0d, want sum=44", sum);
    end
    drive(120, 45, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (sum !== 8'h00 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got sum=%0h ovf=%0b, want sum=00 ovf=0", sum, ovf);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum !== 8'h00 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: got sum=%0h ovf=%0b, want sum=00 ovf=0", sum, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(-128, 1, 1'b1);
    drive(5, 5, 1'b1);

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
